// File: rtl/i2c_request_arbiter.sv
// Round-robin arbiter that shares one byte-level I2C master between NUM_REQ requesters.
// Sequences IDLE -> ISSUE -> WAIT -> RESP with a bounded wait on the master's done pulse.
module i2c_request_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDRWIDTH = 7,
  parameter int DATAWIDTH = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDRWIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]             req_rw,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic                           rsp_nack,
  output logic                           rsp_timeout,
  output logic [DATAWIDTH-1:0]           rsp_rdata,
  output logic                           m_enable,
  output logic [ADDRWIDTH-1:0]           m_addr,
  output logic                           m_rw,
  output logic [DATAWIDTH-1:0]           m_wdata,
  input  logic                           m_done,
  input  logic                           m_nack,
  input  logic [DATAWIDTH-1:0]           m_rdata,
  output logic                           busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int CNTW = $clog2(TIMEOUT);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ISSUE = 4'b0010,
    WAIT  = 4'b0100,
    RESP  = 4'b1000
  } state_e;

  state_e                 state_q;
  logic [IDW-1:0]         last_grant_q, grant_q;
  logic [CNTW-1:0]        cnt_q;
  logic [NUM_REQ-1:0]     req_ready_q, rsp_valid_q;
  logic                   rsp_nack_q, rsp_timeout_q, m_enable_q, m_rw_q;
  logic [DATAWIDTH-1:0]   rsp_rdata_q, m_wdata_q;
  logic [ADDRWIDTH-1:0]   m_addr_q;

  logic                   found_d;
  logic [IDW-1:0]         win_d;
  int unsigned            idx;

  // Rotating priority: search starts just after the last granted requester.
  always_comb begin
    found_d = 1'b0;
    win_d   = '0;
    idx     = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last_grant_q) + i) % NUM_REQ;
      if (!found_d && req_valid[IDW'(idx)]) begin
        found_d = 1'b1;
        win_d   = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= IDW'(NUM_REQ - 1);
      grant_q       <= '0;
      cnt_q         <= '0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_nack_q    <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      m_enable_q    <= 1'b0;
      m_addr_q      <= '0;
      m_rw_q        <= 1'b0;
      m_wdata_q     <= '0;
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      m_enable_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found_d) begin
            grant_q     <= win_d;
            m_addr_q    <= req_addr[win_d*ADDRWIDTH +: ADDRWIDTH];
            m_rw_q      <= req_rw[win_d];
            m_wdata_q   <= req_wdata[win_d*DATAWIDTH +: DATAWIDTH];
            req_ready_q <= NUM_REQ'(1) << win_d;
            // Registered so the strobe is high exactly while in ISSUE.
            m_enable_q  <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (m_done) begin
            rsp_nack_q    <= m_nack;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= (!m_rw_q || m_nack) ? '0 : m_rdata;
            rsp_valid_q   <= NUM_REQ'(1) << grant_q;
            state_q       <= RESP;
          end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
            rsp_nack_q    <= 1'b0;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_valid_q   <= NUM_REQ'(1) << grant_q;
            state_q       <= RESP;
          end
        end
        RESP: begin
          last_grant_q <= grant_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_nack    = rsp_nack_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign m_enable    = m_enable_q;
  assign m_addr      = m_addr_q;
  assign m_rw        = m_rw_q;
  assign m_wdata     = m_wdata_q;
  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_q;

endmodule

// File: tb/tb_i2c_request_arbiter.sv
// Self-checking bench for i2c_request_arbiter: directed scenarios plus randomized
// transactions checked against a round-robin reference model.
module tb_i2c_request_arbiter;
  localparam int N  = 4;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_rw, req_ready, rsp_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic              rsp_nack, rsp_timeout, m_enable, m_rw, m_done, m_nack, busy;
  logic [DW-1:0]     rsp_rdata, m_wdata, m_rdata;
  logic [AW-1:0]     m_addr;
  logic [1:0]        grant_id;

  int errors = 0;
  int checks = 0;
  int model_last;

  i2c_request_arbiter #(.NUM_REQ(N), .ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_nack(rsp_nack),
    .rsp_timeout(rsp_timeout), .rsp_rdata(rsp_rdata), .m_enable(m_enable), .m_addr(m_addr),
    .m_rw(m_rw), .m_wdata(m_wdata), .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic rw, input logic [DW-1:0] d);
    req_addr[i*AW +: AW]  = a;
    req_rw[i]             = rw;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; req_valid = '0; m_done = 1'b0; m_nack = 1'b0; m_rdata = '0;
    tick();
    rst = 1'b0;
    model_last = N - 1;
  endtask

  // Reference: first requested index after the last grant, wrapping around.
  function automatic int pick(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int j = (model_last + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic test_reset();
    req_addr = '1; req_wdata = '1; req_rw = '1;
    pulse_reset();
    checks++; if ({req_ready, rsp_valid, m_enable, busy} !== '0) begin errors++;
      $display("FAIL reset_strobes got=%b exp=0", {req_ready, rsp_valid, m_enable, busy}); end
    checks++; if ({rsp_nack, rsp_timeout, rsp_rdata} !== '0) begin errors++;
      $display("FAIL reset_rsp got=%h exp=0", {rsp_nack, rsp_timeout, rsp_rdata}); end
    checks++; if ({m_addr, m_rw, m_wdata, grant_id} !== '0) begin errors++;
      $display("FAIL reset_master got=%h exp=0", {m_addr, m_rw, m_wdata, grant_id}); end
  endtask

  task automatic test_single_write();
    set_req(2, 7'h4C, 1'b0, 8'hA5);
    req_valid = 4'b0100;
    tick();
    checks++; if (req_ready !== 4'b0100 || m_enable !== 1'b1) begin errors++;
      $display("FAIL wr_accept ready=%b en=%b exp ready=0100 en=1", req_ready, m_enable); end
    checks++; if (m_addr !== 7'h4C || m_wdata !== 8'hA5 || m_rw !== 1'b0 || grant_id !== 2'd2) begin errors++;
      $display("FAIL wr_latch addr=%h wdata=%h rw=%b gid=%0d exp 4c a5 0 2", m_addr, m_wdata, m_rw, grant_id); end
    req_valid = '0;
    tick();
    checks++; if (m_enable !== 1'b0 || req_ready !== '0 || busy !== 1'b1) begin errors++;
      $display("FAIL wr_wait en=%b ready=%b busy=%b exp 0 0000 1", m_enable, req_ready, busy); end
    repeat (8) tick();
    m_done = 1'b1; m_rdata = 8'h77;
    tick();
    m_done = 1'b0;
    checks++; if (rsp_valid !== 4'b0100 || rsp_nack !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 8'h00) begin errors++;
      $display("FAIL wr_rsp valid=%b nack=%b to=%b rdata=%h exp 0100 0 0 00", rsp_valid, rsp_nack, rsp_timeout, rsp_rdata); end
    tick();
    checks++; if (busy !== 1'b0 || rsp_valid !== '0) begin errors++;
      $display("FAIL wr_idle busy=%b valid=%b exp 0 0000", busy, rsp_valid); end
    model_last = 2;
  endtask

  task automatic test_read();
    set_req(0, 7'h21, 1'b1, 8'h00);
    req_valid = 4'b0001;
    tick();
    checks++; if (req_ready !== 4'b0001 || m_rw !== 1'b1) begin errors++;
      $display("FAIL rd_accept ready=%b rw=%b exp 0001 1", req_ready, m_rw); end
    req_valid = '0;
    tick();
    repeat (3) tick();
    m_done = 1'b1; m_nack = 1'b0; m_rdata = 8'h3C;
    tick();
    m_done = 1'b0;
    checks++; if (rsp_valid !== 4'b0001 || rsp_rdata !== 8'h3C || rsp_nack !== 1'b0) begin errors++;
      $display("FAIL rd_rsp valid=%b rdata=%h nack=%b exp 0001 3c 0", rsp_valid, rsp_rdata, rsp_nack); end
    tick();
    model_last = 0;
  endtask

  task automatic test_nack();
    set_req(1, 7'h50, 1'b1, 8'h00);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    m_done = 1'b1; m_nack = 1'b1; m_rdata = 8'hFF;
    tick();
    m_done = 1'b0; m_nack = 1'b0;
    checks++; if (rsp_valid !== 4'b0010 || rsp_nack !== 1'b1 || rsp_rdata !== 8'h00 || rsp_timeout !== 1'b0) begin errors++;
      $display("FAIL nack_rsp valid=%b nack=%b rdata=%h to=%b exp 0010 1 00 0", rsp_valid, rsp_nack, rsp_rdata, rsp_timeout); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nack_idle busy=%b exp 0", busy); end
    model_last = 1;
  endtask

  task automatic test_round_robin();
    int cnt [N];
    int w;
    logic [N-1:0] expv;
    pulse_reset();
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      set_req(i, AW'($urandom), 1'b0, DW'($urandom));
    end
    req_valid = '1;
    for (int t = 0; t < 2 * N; t++) begin
      w = pick(req_valid);
      expv = N'(1) << w;
      tick();
      checks++; if (req_ready !== expv || m_addr !== req_addr[w*AW +: AW]) begin errors++;
        $display("FAIL rr_grant txn=%0d ready=%b addr=%h exp %b %h", t, req_ready, m_addr, expv, req_addr[w*AW +: AW]); end
      tick();
      repeat ($urandom_range(0, 5)) tick();
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      checks++; if (rsp_valid !== expv) begin errors++;
        $display("FAIL rr_rsp txn=%0d valid=%b exp %b", t, rsp_valid, expv); end
      else cnt[w]++;
      tick();
      model_last = w;
    end
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      checks++; if (cnt[i] !== 2) begin errors++; $display("FAIL rr_fair req=%0d got=%0d exp=2", i, cnt[i]); end
    end
  endtask

  task automatic test_timeout();
    int w1, w2;
    logic [N-1:0] mask;
    mask = 4'b1010;
    set_req(1, 7'h11, 1'b1, 8'h00);
    set_req(3, 7'h33, 1'b0, 8'h5A);
    req_valid = mask;
    w1 = pick(mask);
    tick();
    checks++; if (req_ready !== N'(1) << w1) begin errors++;
      $display("FAIL to_grant1 ready=%b exp %b", req_ready, N'(1) << w1); end
    req_valid[w1] = 1'b0;
    tick();
    for (int j = 1; j < TO; j++) begin
      tick();
      checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL to_early cyc=%0d valid=%b exp 0000", j, rsp_valid); end
    end
    tick();
    checks++; if (rsp_valid !== N'(1) << w1 || rsp_timeout !== 1'b1 || rsp_nack !== 1'b0 || rsp_rdata !== '0) begin errors++;
      $display("FAIL to_rsp valid=%b to=%b nack=%b rdata=%h exp %b 1 0 00", rsp_valid, rsp_timeout, rsp_nack, rsp_rdata, N'(1) << w1); end
    model_last = w1;
    w2 = pick(req_valid);
    tick();
    checks++; if (busy !== 1'b0 || req_ready !== '0) begin errors++;
      $display("FAIL to_idle busy=%b ready=%b exp 0 0000", busy, req_ready); end
    tick();
    checks++; if (req_ready !== N'(1) << w2) begin errors++;
      $display("FAIL to_grant2 ready=%b exp %b", req_ready, N'(1) << w2); end
    req_valid = '0;
    tick();
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    checks++; if (rsp_valid !== N'(1) << w2 || rsp_timeout !== 1'b0) begin errors++;
      $display("FAIL to_second valid=%b to=%b exp %b 0", rsp_valid, rsp_timeout, N'(1) << w2); end
    tick();
    model_last = w2;
  endtask

  task automatic test_done_at_terminal();
    int w;
    set_req(2, 7'h2A, 1'b1, 8'h00);
    req_valid = 4'b0100;
    w = pick(req_valid);
    tick();
    req_valid = '0;
    tick();
    repeat (TO - 1) tick();
    m_done = 1'b1; m_nack = 1'b0; m_rdata = 8'hC3;
    tick();
    m_done = 1'b0;
    checks++; if (rsp_valid !== N'(1) << w || rsp_timeout !== 1'b0 || rsp_rdata !== 8'hC3) begin errors++;
      $display("FAIL term_race valid=%b to=%b rdata=%h exp %b 0 c3", rsp_valid, rsp_timeout, rsp_rdata, N'(1) << w); end
    tick();
    model_last = w;
  endtask

  task automatic test_reset_mid_wait();
    set_req(2, 7'h7F, 1'b0, 8'hEE);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    repeat (3) tick();
    rst = 1'b1; m_done = 1'b1;
    tick();
    rst = 1'b0; m_done = 1'b0;
    model_last = N - 1;
    checks++; if ({req_ready, rsp_valid, m_enable, busy, rsp_nack, rsp_timeout} !== '0) begin errors++;
      $display("FAIL rstw_ctrl got=%b exp=0", {req_ready, rsp_valid, m_enable, busy, rsp_nack, rsp_timeout}); end
    checks++; if ({rsp_rdata, m_addr, m_rw, m_wdata, grant_id} !== '0) begin errors++;
      $display("FAIL rstw_data got=%h exp=0", {rsp_rdata, m_addr, m_rw, m_wdata, grant_id}); end
    set_req(0, 7'h0A, 1'b1, 8'h00);
    req_valid = 4'b0001;
    tick();
    checks++; if (req_ready !== 4'b0001 || m_enable !== 1'b1) begin errors++;
      $display("FAIL rstw_grant ready=%b en=%b exp 0001 1", req_ready, m_enable); end
    req_valid = '0;
    tick();
    m_done = 1'b1; m_rdata = 8'h96;
    tick();
    m_done = 1'b0;
    checks++; if (rsp_valid !== 4'b0001 || rsp_rdata !== 8'h96) begin errors++;
      $display("FAIL rstw_rsp valid=%b rdata=%h exp 0001 96", rsp_valid, rsp_rdata); end
    tick();
    model_last = 0;
  endtask

  task automatic test_random();
    int w, mode;
    logic [N-1:0] mask, expv;
    logic nk, exp_nack, exp_to;
    logic [DW-1:0] rd, exp_rd;
    logic [AW-1:0] exp_addr;
    for (int t = 0; t < 40; t++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) set_req(i, AW'($urandom), 1'($urandom), DW'($urandom));
      req_valid = mask;
      w = pick(mask);
      expv = N'(1) << w;
      exp_addr = req_addr[w*AW +: AW];
      m_done = 1'($urandom);
      tick();
      checks++; if (req_ready !== expv || m_enable !== 1'b1 || grant_id !== 2'(w)) begin errors++;
        $display("FAIL rnd_grant txn=%0d ready=%b en=%b gid=%0d exp %b 1 %0d", t, req_ready, m_enable, grant_id, expv, w); end
      checks++; if (m_addr !== exp_addr || m_rw !== req_rw[w] || m_wdata !== req_wdata[w*DW +: DW]) begin errors++;
        $display("FAIL rnd_latch txn=%0d addr=%h rw=%b wdata=%h exp %h %b %h", t, m_addr, m_rw, m_wdata, exp_addr, req_rw[w], req_wdata[w*DW +: DW]); end
      req_valid[w] = 1'b0;
      m_done = 1'($urandom);
      tick();
      m_done = 1'b0;
      mode = $urandom_range(0, TO);
      nk = 1'($urandom);
      rd = DW'($urandom);
      if (mode == TO) begin
        repeat (TO) tick();
        exp_nack = 1'b0; exp_to = 1'b1; exp_rd = '0;
      end else begin
        repeat (mode) tick();
        m_done = 1'b1; m_nack = nk; m_rdata = rd;
        tick();
        m_done = 1'b0; m_nack = 1'b0;
        exp_nack = nk; exp_to = 1'b0;
        exp_rd = (req_rw[w] && !nk) ? rd : '0;
      end
      checks++; if (rsp_valid !== expv || rsp_nack !== exp_nack || rsp_timeout !== exp_to || rsp_rdata !== exp_rd) begin errors++;
        $display("FAIL rnd_rsp txn=%0d valid=%b nack=%b to=%b rdata=%h exp %b %b %b %h", t, rsp_valid, rsp_nack, rsp_timeout, rsp_rdata, expv, exp_nack, exp_to, exp_rd); end
      tick();
      checks++; if (busy !== 1'b0 || m_addr !== exp_addr) begin errors++;
        $display("FAIL rnd_hold txn=%0d busy=%b addr=%h exp 0 %h", t, busy, m_addr, exp_addr); end
      model_last = w;
    end
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b0; req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    m_done = 1'b0; m_nack = 1'b0; m_rdata = '0;
    model_last = N - 1;
    test_reset();
    test_single_write();
    test_read();
    test_nack();
    test_round_robin();
    test_timeout();
    test_done_at_terminal();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_request_arbiter.md
# i2c_request_arbiter

Round-robin arbiter and transaction sequencer that shares one I2C byte-level master between up to NUM_REQ on-chip requesters. Each request names a 7-bit slave address, a direction and one data byte. The block selects one request, launches it on the master, waits for completion or timeout, and returns status and read data to the winning requester. It sits between the memory-subsystem clients and the I2C master FSM that drives SCL/SDA.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- ADDRWIDTH, 7: slave address width.
- DATAWIDTH, 8: data byte width.
- TIMEOUT, 1024: maximum WAIT cycles before abort (≥ 4).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Synchronous, active-high; one clock.
- req_valid  in  NUM_REQ  per-requester request pending; held until req_ready.
- req_addr  in  NUM_REQ*ADDRWIDTH  slave address; slice i belongs to requester i.
- req_rw  in  NUM_REQ  1 = read, 0 = write.
- req_wdata  in  NUM_REQ*DATAWIDTH  write byte; slice i belongs to requester i.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_nack  out  1  slave NACKed; valid with rsp_valid.
- rsp_timeout  out  1  master did not finish; valid with rsp_valid.
- rsp_rdata  out  DATAWIDTH  read byte; 0 for writes, NACK or timeout.
- m_enable  out  1  one-cycle launch strobe to the master.
- m_addr  out  ADDRWIDTH  latched slave address.
- m_rw  out  1  latched direction.
- m_wdata  out  DATAWIDTH  latched write byte.
- m_done  in  1  master completion pulse (after STOP).
- m_nack  in  1  NACK status; qualified by m_done.
- m_rdata  in  DATAWIDTH  read byte; qualified by m_done.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. State is one-hot encoded.
- IDLE: if any req_valid is high, pick the first set bit searching from last_grant+1 upward, with wrap-around.
  - Latch that requester's addr, rw and wdata into m_addr, m_rw and m_wdata.
  - Set grant_id, pulse req_ready[winner], and go to ISSUE.
- ISSUE: drive m_enable=1 for exactly this cycle, clear the timeout counter, and go to WAIT.
- WAIT: increment the timeout counter each cycle.
  - On m_done: capture m_nack and m_rdata (force rdata to 0 if the transaction was a write or was NACKed), then go to RESP.
  - If the counter reaches TIMEOUT-1 without m_done: set rsp_timeout=1, rsp_nack=0, rdata=0, then go to RESP.
- RESP: pulse rsp_valid[grant_id], set last_grant=grant_id, and go to IDLE.
- m_done is sampled only in WAIT and ignored in every other state.
- A requester that drops req_valid before its req_ready pulse is simply not granted. No transaction is started for it.
- m_addr, m_rw, m_wdata, rsp_* data and grant_id hold their last values between transactions.

## Timing
- Reset values:
  - State IDLE; last_grant = NUM_REQ-1, so requester 0 wins first.
  - req_ready, rsp_valid, m_enable, busy = 0.
  - rsp_nack, rsp_timeout, rsp_rdata = 0.
  - m_addr, m_rw, m_wdata, grant_id = 0.
- Request seen in IDLE at cycle T:
  - req_ready and m_enable are high at T+1.
  - WAIT starts at T+2.
- m_done at cycle K (in WAIT):
  - rsp_valid high at K+1.
  - IDLE at K+2; the next arbitration decision is made at K+2.
- Back-to-back throughput: one transaction per (master latency + 4) cycles.
- m_done and the timeout terminal count in the same cycle: m_done wins, rsp_timeout=0.
- Reset mid-WAIT or mid-RESP:
  - The next cycle shows reset values, with no rsp_valid and no m_enable.
  - The master is expected to be reset by the same rst.
- New requests arriving during ISSUE, WAIT or RESP wait in IDLE arbitration. They are never dropped while req_valid is held.

## Test plan
- Single write: req 2, addr 0x4C, rw=0, wdata 0xA5 at T. Expected:
  - req_ready[2] and m_enable at T+1 with m_addr=0x4C, m_wdata=0xA5.
  - m_done at T+10 → rsp_valid[2] at T+11, rsp_nack=0, rdata=0.
- Read: req 0, rw=1; master returns m_rdata=0x3C at m_done → rsp_valid[0] with rsp_rdata=0x3C, rsp_nack=0.
- Round-robin fairness: all four req_valid held continuously → grant order 0,1,2,3,0. Each requester gets exactly one rsp_valid per four transactions.
- NACK: m_done with m_nack=1 on a read → rsp_nack=1, rsp_rdata=0, rsp_timeout=0, FSM back in IDLE.
- Timeout: TIMEOUT=16, m_done never asserted → rsp_valid 16 cycles after WAIT entry with rsp_timeout=1. Arbitration of a pending second requester follows two cycles later.
- Reset during WAIT: assert rst for one cycle → all outputs at reset values next cycle. A subsequent request from requester 0 completes normally.
